threshold2_mul_pipe: RTL and testbench
======================================

Name: threshold2_mul_pipe

Overview:
Parametrised, pipelined multiplier for the threshold2 image-processing datapath. It replaces the fixed 8x14->21 unsigned combinational product with these additions:
- configurable operand and result widths and pipeline depth;
- per-transaction signed/unsigned mode;
- post-scale right shift with optional round-half-up;
- saturation and an overflow flag and counter;
- valid/ready handshake on both sides with full backpressure.

Parameters:
DIN0_WIDTH, 8, width of operand a
DIN1_WIDTH, 14, width of operand b
DOUT_WIDTH, 21, result width
NUM_STAGE, 3, latency in cycles, legal 1..4
SHIFT, 0, arithmetic right shift of full product, 0..DIN0_WIDTH+DIN1_WIDTH-1
ROUND, 0, 1 = add 2^(SHIFT-1) before shift (ignored when SHIFT=0)
SATURATE, 1, 1 = clamp to DOUT range; 0 = keep low DOUT_WIDTH bits
OVF_CNT_WIDTH, 16, width of overflow counter

Ports:
ap_clk  in  1  clock, all state on rising edge
ap_rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts beat this cycle
din0  in  DIN0_WIDTH  operand a
din1  in  DIN1_WIDTH  operand b
signed_mode  in  1  1 = two's-complement operands/result, sampled with beat
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
dout  out  DOUT_WIDTH  scaled, saturated/truncated result
out_ovf  out  1  result exceeded DOUT range (aligned with dout)
ovf_clr  in  1  synchronous clear of ovf_count
ovf_count  out  OVF_CNT_WIDTH  saturating count of overflowed results delivered

Behaviour:
- Reset (asynchronous, ap_rst_n=0):
  - All stage valid bits clear; dout=0, out_ovf=0, out_valid=0, ovf_count=0.
  - in_ready=1 as soon as reset releases.
  - In-flight beats are discarded; nothing is emitted after reset for them.
- Handshake:
  - Beat accepted when in_valid && in_ready.
  - Result consumed when out_valid && out_ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall, combinational.
  - On stall every stage holds (global clock-enable). Bubbles are not collapsed.
  - dout, out_ovf and out_valid stay stable while stalled.
- Latency:
  - Exactly NUM_STAGE cycles from accept to out_valid when no stall occurs.
  - Throughput is 1 beat/cycle.
  - Order is preserved; no beat is lost or duplicated under any out_ready pattern.
- Arithmetic, with P = DIN0_WIDTH+DIN1_WIDTH:
  - signed_mode=1: sign-extend operands to P bits; otherwise zero-extend. Product is exact in P bits.
  - If ROUND=1 and SHIFT>0, add 2^(SHIFT-1) in P+1 bits, then shift right by SHIFT (arithmetic if signed, logical if unsigned).
  - Range:
    - signed: [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1];
    - unsigned: [0, 2^DOUT_WIDTH-1].
  - Out of range sets out_ovf=1.
  - SATURATE=1 clamps to the nearest bound; SATURATE=0 outputs the low DOUT_WIDTH bits.
- Pipeline allocation (verification relies only on total latency):
  - stage 1 registers operands and mode;
  - the multiply spans the middle stages;
  - round/shift/saturate sit in the final stage.
  - NUM_STAGE=1 does everything combinationally before one register.
- ovf_count:
  - Increments on each consumed beat with out_ovf=1; saturates at all-ones.
  - ovf_clr has priority over a same-cycle increment (result 0).

Decomposition:
- Shared package threshold2_mul_pkg holds:
  - localparam function for product width;
  - saturation bound constants per mode;
  - NUM_STAGE legal-range check.
- One sub-module, threshold2_mul_sat_scale: combinational round/shift/saturate on a P-bit product, producing dout and out_ovf.
- The pipeline, handshake and counter stay in the top module.

Test Plan:
- Defaults, unsigned, out_ready=1: din0=200, din1=1000 -> dout=200000, out_ovf=0, out_valid exactly 3 cycles after accept.
- Defaults, unsigned: din0=255, din1=16383 -> dout=2097151, out_ovf=1, ovf_count=1. With SATURATE=0 -> dout=4177665 mod 2^21 = 2080513, out_ovf=1.
- Signed mode:
  - din0=8'hFF, din1=5 -> dout=21'h1FFFFB (-5), ovf=0.
  - din0=8'h80, din1=14'h2000 -> dout=1048575, ovf=1.
  - Interleave signed/unsigned beats back-to-back; each result follows its own sampled mode.
- SHIFT=4, ROUND=1: 3*3 -> dout=1; 7*1 -> dout=0; 8*1 -> dout=1. With ROUND=0: 8*1 -> dout=0.
- Backpressure:
  - Stream 10 random beats with out_ready toggling randomly and out_ready=0 for 6 consecutive cycles.
  - Required: in_ready low exactly while stalled, dout held stable, all 10 results in order and matching the scoreboard.
- Reset with 3 beats in flight: assert ap_rst_n=0 for 1 cycle -> out_valid=0, dout=0, ovf_count=0 immediately; no stale result appears afterwards. Also cover ovf_clr coincident with an overflowing consume -> ovf_count=0.

Source files
------------

// File: rtl/threshold2_mul_pkg.sv
// Shared definitions for the threshold2 multiplier: operand mode, product width,
// output saturation bounds and the legal pipeline depth range.
package threshold2_mul_pkg;

   typedef enum logic {
      MODE_UNSIGNED = 1'b0,
      MODE_SIGNED   = 1'b1
   } mode_e;

   localparam int MIN_STAGE = 1;
   localparam int MAX_STAGE = 4;

   function automatic int prod_width(input int w0, input int w1);
      return w0 + w1;
   endfunction

   function automatic bit num_stage_ok(input int n);
      return (n >= MIN_STAGE) && (n <= MAX_STAGE);
   endfunction

   // Bounds are returned as 64-bit signed values; callers size them down.
   function automatic longint bound_hi(input int w, input mode_e m);
      return (m == MODE_SIGNED) ? (longint'(1) <<< (w - 1)) - 64'sd1
                                : (longint'(1) <<< w) - 64'sd1;
   endfunction

   function automatic longint bound_lo(input int w, input mode_e m);
      return (m == MODE_SIGNED) ? -(longint'(1) <<< (w - 1)) : 64'sd0;
   endfunction

endpackage

// File: rtl/threshold2_mul_sat_scale.sv
// Combinational post-scale of a full-width product: optional round-half-up,
// arithmetic/logical right shift, then range check with saturate or truncate.
module threshold2_mul_sat_scale
   import threshold2_mul_pkg::*;
#(
   parameter int P          = 22,
   parameter int DOUT_WIDTH = 21,
   parameter int SHIFT      = 0,
   parameter int ROUND      = 0,
   parameter int SATURATE   = 1
) (
   input  logic [P-1:0]          prod,
   input  mode_e                 mode,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  ovf
);

   // Two guard bits keep the rounding add and the unsigned bound representable.
   localparam int CW  = (P > DOUT_WIDTH) ? P + 2 : DOUT_WIDTH + 2;
   localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [CW-1:0] RND  = (ROUND != 0 && SHIFT > 0) ? (CW'(1) << RSH) : CW'(0);
   localparam logic signed [CW-1:0] U_HI = CW'(bound_hi(DOUT_WIDTH, MODE_UNSIGNED));
   localparam logic signed [CW-1:0] U_LO = CW'(bound_lo(DOUT_WIDTH, MODE_UNSIGNED));
   localparam logic signed [CW-1:0] S_HI = CW'(bound_hi(DOUT_WIDTH, MODE_SIGNED));
   localparam logic signed [CW-1:0] S_LO = CW'(bound_lo(DOUT_WIDTH, MODE_SIGNED));

   logic signed [CW-1:0] ext;
   logic signed [CW-1:0] scaled;
   logic signed [CW-1:0] hi;
   logic signed [CW-1:0] lo;
   logic                 over;
   logic                 under;

   always_comb begin
      if (mode == MODE_SIGNED) begin
         ext = {{(CW-P){prod[P-1]}}, prod};
         hi  = S_HI;
         lo  = S_LO;
      end else begin
         ext = {{(CW-P){1'b0}}, prod};
         hi  = U_HI;
         lo  = U_LO;
      end
      // Unsigned values are zero-extended, so >>> degenerates to a logical shift.
      scaled = (ext + RND) >>> SHIFT;
      over   = scaled > hi;
      under  = scaled < lo;
      ovf    = over | under;
      if (SATURATE != 0 && over) begin
         dout = hi[DOUT_WIDTH-1:0];
      end else if (SATURATE != 0 && under) begin
         dout = lo[DOUT_WIDTH-1:0];
      end else begin
         dout = scaled[DOUT_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/threshold2_mul_pipe.sv
// Pipelined signed/unsigned multiplier with scaling, saturation, overflow count
// and valid/ready handshake; a single global enable stalls every stage.
module threshold2_mul_pipe
   import threshold2_mul_pkg::*;
#(
   parameter int DIN0_WIDTH    = 8,
   parameter int DIN1_WIDTH    = 14,
   parameter int DOUT_WIDTH    = 21,
   parameter int NUM_STAGE     = 3,
   parameter int SHIFT         = 0,
   parameter int ROUND         = 0,
   parameter int SATURATE      = 1,
   parameter int OVF_CNT_WIDTH = 16
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DIN0_WIDTH-1:0]    din0,
   input  logic [DIN1_WIDTH-1:0]    din1,
   input  logic                     signed_mode,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DOUT_WIDTH-1:0]    dout,
   output logic                     out_ovf,
   input  logic                     ovf_clr,
   output logic [OVF_CNT_WIDTH-1:0] ovf_count
);

   localparam int P   = prod_width(DIN0_WIDTH, DIN1_WIDTH);
   localparam int NPD = (NUM_STAGE > 2) ? NUM_STAGE - 2 : 0;

   genvar gi;

   if (!num_stage_ok(NUM_STAGE)) begin : g_bad_num_stage
      $error("threshold2_mul_pipe: NUM_STAGE must be within 1..4");
   end

   logic                     stall;
   logic                     advance;
   logic [DIN0_WIDTH-1:0]    mul_a;
   logic [DIN1_WIDTH-1:0]    mul_b;
   mode_e                    mul_mode;
   logic [P-1:0]             ext_a;
   logic [P-1:0]             ext_b;
   logic [P-1:0]             mul_prod;
   logic [P-1:0]             fin_prod;
   mode_e                    fin_mode;
   logic [DOUT_WIDTH-1:0]    fin_dout;
   logic                     fin_ovf;
   logic [DOUT_WIDTH-1:0]    dout_reg;
   logic                     ovf_reg;
   logic [OVF_CNT_WIDTH-1:0] ovf_count_reg;

   assign stall    = out_valid && !out_ready;
   assign advance  = !stall;
   assign in_ready = advance;

   // Valid travels alongside the data; bubbles are carried, never squeezed out.
   for (gi = 0; gi < NUM_STAGE; gi++) begin : g_vld
      logic v_reg;
      logic v_in;
      if (gi == 0) begin : g_first
         assign v_in = in_valid;
      end else begin : g_next
         assign v_in = g_vld[gi-1].v_reg;
      end
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
         if (!ap_rst_n) begin
            v_reg <= 1'b0;
         end else if (advance) begin
            v_reg <= v_in;
         end
      end
   end

   assign out_valid = g_vld[NUM_STAGE-1].v_reg;

   if (NUM_STAGE == 1) begin : g_comb_ops
      assign mul_a    = din0;
      assign mul_b    = din1;
      assign mul_mode = mode_e'(signed_mode);
   end else begin : g_op_reg
      logic [DIN0_WIDTH-1:0] a_reg;
      logic [DIN1_WIDTH-1:0] b_reg;
      mode_e                 mode_reg;
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
         if (!ap_rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            mode_reg <= MODE_UNSIGNED;
         end else if (advance) begin
            a_reg    <= din0;
            b_reg    <= din1;
            mode_reg <= mode_e'(signed_mode);
         end
      end
      assign mul_a    = a_reg;
      assign mul_b    = b_reg;
      assign mul_mode = mode_reg;
   end

   // Low P bits of the extended product are exact for both signednesses.
   always_comb begin
      if (mul_mode == MODE_SIGNED) begin
         ext_a = {{DIN1_WIDTH{mul_a[DIN0_WIDTH-1]}}, mul_a};
         ext_b = {{DIN0_WIDTH{mul_b[DIN1_WIDTH-1]}}, mul_b};
      end else begin
         ext_a = {{DIN1_WIDTH{1'b0}}, mul_a};
         ext_b = {{DIN0_WIDTH{1'b0}}, mul_b};
      end
      mul_prod = ext_a * ext_b;
   end

   if (NPD == 0) begin : g_no_pd
      assign fin_prod = mul_prod;
      assign fin_mode = mul_mode;
   end else begin : g_pd_chain
      // Trailing product registers give the tools room to retime the multiplier.
      for (gi = 0; gi < NPD; gi++) begin : g_pd
         logic [P-1:0] p_reg;
         logic [P-1:0] p_in;
         mode_e        m_reg;
         mode_e        m_in;
         if (gi == 0) begin : g_first
            assign p_in = mul_prod;
            assign m_in = mul_mode;
         end else begin : g_next
            assign p_in = g_pd[gi-1].p_reg;
            assign m_in = g_pd[gi-1].m_reg;
         end
         always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
               p_reg <= '0;
               m_reg <= MODE_UNSIGNED;
            end else if (advance) begin
               p_reg <= p_in;
               m_reg <= m_in;
            end
         end
      end
      assign fin_prod = g_pd[NPD-1].p_reg;
      assign fin_mode = g_pd[NPD-1].m_reg;
   end

   threshold2_mul_sat_scale #(
      .P          (P),
      .DOUT_WIDTH (DOUT_WIDTH),
      .SHIFT      (SHIFT),
      .ROUND      (ROUND),
      .SATURATE   (SATURATE)
   ) u_sat_scale (
      .prod (fin_prod),
      .mode (fin_mode),
      .dout (fin_dout),
      .ovf  (fin_ovf)
   );

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         dout_reg <= '0;
         ovf_reg  <= 1'b0;
      end else if (advance) begin
         dout_reg <= fin_dout;
         ovf_reg  <= fin_ovf;
      end
   end

   // Clear wins over a same-cycle increment; the count sticks at all-ones.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         ovf_count_reg <= '0;
      end else if (ovf_clr) begin
         ovf_count_reg <= '0;
      end else if (out_valid && out_ready && ovf_reg && !(&ovf_count_reg)) begin
         ovf_count_reg <= ovf_count_reg + OVF_CNT_WIDTH'(1);
      end
   end

   assign dout      = dout_reg;
   assign out_ovf   = ovf_reg;
   assign ovf_count = ovf_count_reg;

endmodule

// File: tb/tb_threshold2_mul_pipe.sv
// Scoreboard bench: four configurations of threshold2_mul_pipe share operands;
// expectations are queued on accept and popped by a monitor on each consume.
module tb_threshold2_mul_pipe;

   typedef struct packed {
      logic [20:0] d;
      logic        o;
   } exp_t;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic [3:0]  iv;
   logic [3:0]  irdy;
   logic [3:0]  ov;
   logic [3:0]  ovf;
   logic [3:0]  ordy;
   logic        rdy0;
   logic        clr;
   logic [7:0]  din0;
   logic [13:0] din1;
   logic        sm;
   logic [20:0] dq  [4];
   logic [15:0] cnt [4];

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   exp_t q3[$];

   int n_vec;
   int n_fail;

   logic        prev_stall;
   logic [20:0] prev_dout;
   logic        prev_ovf;

   assign ordy = {3'b111, rdy0};

   always #5 ap_clk = ~ap_clk;

   threshold2_mul_pipe #(.NUM_STAGE(3)) u_dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
      .din0(din0), .din1(din1), .signed_mode(sm), .out_valid(ov[0]), .out_ready(rdy0),
      .dout(dq[0]), .out_ovf(ovf[0]), .ovf_clr(clr), .ovf_count(cnt[0]));

   threshold2_mul_pipe #(.SATURATE(0)) u_sat0 (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
      .din0(din0), .din1(din1), .signed_mode(sm), .out_valid(ov[1]), .out_ready(1'b1),
      .dout(dq[1]), .out_ovf(ovf[1]), .ovf_clr(1'b0), .ovf_count(cnt[1]));

   threshold2_mul_pipe #(.SHIFT(4), .ROUND(1), .NUM_STAGE(1)) u_rnd (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
      .din0(din0), .din1(din1), .signed_mode(sm), .out_valid(ov[2]), .out_ready(1'b1),
      .dout(dq[2]), .out_ovf(ovf[2]), .ovf_clr(1'b0), .ovf_count(cnt[2]));

   threshold2_mul_pipe #(.SHIFT(4), .ROUND(0), .NUM_STAGE(4)) u_trn (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(iv[3]), .in_ready(irdy[3]),
      .din0(din0), .din1(din1), .signed_mode(sm), .out_valid(ov[3]), .out_ready(1'b1),
      .dout(dq[3]), .out_ovf(ovf[3]), .ovf_clr(1'b0), .ovf_count(cnt[3]));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, want, want);
      end
   endtask

   task automatic push_exp(input int k, input exp_t e);
      case (k)
         0: q0.push_back(e);
         1: q1.push_back(e);
         2: q2.push_back(e);
         default: q3.push_back(e);
      endcase
   endtask

   task automatic pop_exp(input int k, output exp_t e, output bit ok);
      ok = 1'b0;
      e  = '0;
      case (k)
         0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
         2: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
         default: if (q3.size() > 0) begin e = q3.pop_front(); ok = 1'b1; end
      endcase
   endtask

   // Drive one beat into instance k; the expectation is queued once it is accepted.
   task automatic send(input int k, input logic [7:0] a, input logic [13:0] b, input logic s,
                       input logic [20:0] ed, input logic eo);
      bit   acc;
      int   n;
      exp_t e;
      din0  = a;
      din1  = b;
      sm    = s;
      iv[k] = 1'b1;
      acc   = 1'b0;
      n     = 0;
      while (!acc && n < 100) begin
         @(negedge ap_clk);
         acc = irdy[k];
         @(posedge ap_clk);
         #1;
         n++;
      end
      iv[k] = 1'b0;
      if (!acc) begin
         n_vec++;
         n_fail++;
         $display("FAIL accept_timeout[%0d]: beat a=%0d b=%0d not accepted within 100 cycles", k, a, b);
      end else begin
         e.d = ed;
         e.o = eo;
         push_exp(k, e);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q0.size() + q1.size() + q2.size() + q3.size()) > 0 && n < 200) begin
         @(posedge ap_clk);
         #1;
         n++;
      end
      if ((q0.size() + q1.size() + q2.size() + q3.size()) > 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL drain_timeout: %0d results still outstanding, expected 0",
                  q0.size() + q1.size() + q2.size() + q3.size());
      end
      @(posedge ap_clk);
      #1;
   endtask

   always @(negedge ap_clk) begin : mon
      exp_t e;
      bit   ok;
      if (!ap_rst_n) begin
         prev_stall = 1'b0;
      end else begin
         check("in_ready", 32'(irdy[0]), 32'(!(ov[0] && !rdy0)));
         if (prev_stall) begin
            check("hold_valid", 32'(ov[0]), 32'd1);
            check("hold_dout", 32'(dq[0]), 32'(prev_dout));
            check("hold_ovf", 32'(ovf[0]), 32'(prev_ovf));
         end
         prev_stall = ov[0] && !rdy0;
         prev_dout  = dq[0];
         prev_ovf   = ovf[0];
         for (int k = 0; k < 4; k++) begin
            if (ov[k] && ordy[k]) begin
               pop_exp(k, e, ok);
               if (!ok) begin
                  n_vec++;
                  n_fail++;
                  $display("FAIL unexpected_out[%0d]: got dout %0d, expected no result", k, dq[k]);
               end else begin
                  $display("txn inst%0d dout=%0d (0x%0h) ovf=%0d expected dout=%0d ovf=%0d",
                           k, dq[k], dq[k], ovf[k], e.d, e.o);
                  check($sformatf("dout[%0d]", k), 32'(dq[k]), 32'(e.d));
                  check($sformatf("ovf[%0d]", k), 32'(ovf[k]), 32'(e.o));
               end
            end
         end
      end
   end

   logic [7:0]  bp_a [10] = '{8'd3, 8'd100, 8'hFE, 8'd255, 8'd255, 8'h10, 8'd0, 8'h80, 8'd17, 8'h7F};
   logic [13:0] bp_b [10] = '{14'd4, 14'd100, 14'd3, 14'd8000, 14'd9000, 14'h0100, 14'd12345,
                              14'h3FFF, 14'd1000, 14'h1000};
   logic        bp_s [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [20:0] bp_d [10] = '{21'd12, 21'd10000, 21'h1FFFFA, 21'd2040000, 21'd2097151, 21'd4096,
                              21'd0, 21'd128, 21'd17000, 21'd520192};
   logic        bp_o [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   initial begin
      n_vec      = 0;
      n_fail     = 0;
      prev_stall = 1'b0;
      prev_dout  = '0;
      prev_ovf   = 1'b0;
      ap_rst_n   = 1'b0;
      iv         = '0;
      rdy0       = 1'b1;
      clr        = 1'b0;
      din0       = '0;
      din1       = '0;
      sm         = 1'b0;
      repeat (2) @(posedge ap_clk);
      #1;
      check("rst_out_valid", 32'(ov[0]), 32'd0);
      check("rst_dout", 32'(dq[0]), 32'd0);
      check("rst_ovf_count", 32'(cnt[0]), 32'd0);
      ap_rst_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(irdy[0]), 32'd1);

      // Latency: valid appears in the third cycle after the accepting edge.
      send(0, 8'd200, 14'd1000, 1'b0, 21'd200000, 1'b0);
      check("latency_c1", 32'(ov[0]), 32'd0);
      @(posedge ap_clk); #1;
      check("latency_c2", 32'(ov[0]), 32'd0);
      @(posedge ap_clk); #1;
      check("latency_c3", 32'(ov[0]), 32'd1);
      drain();

      send(0, 8'd255, 14'd16383, 1'b0, 21'd2097151, 1'b1);
      drain();
      check("ovf_count_1", 32'(cnt[0]), 32'd1);

      // Signed corners, then signed/unsigned beats interleaved back to back.
      send(0, 8'hFF, 14'd5, 1'b1, 21'h1FFFFB, 1'b0);
      send(0, 8'h80, 14'h2000, 1'b1, 21'd1048575, 1'b1);
      send(0, 8'hFF, 14'd5, 1'b0, 21'd1275, 1'b0);
      send(0, 8'hFF, 14'd5, 1'b1, 21'h1FFFFB, 1'b0);
      send(0, 8'h80, 14'h2000, 1'b0, 21'd1048576, 1'b0);
      send(0, 8'h80, 14'h2000, 1'b1, 21'd1048575, 1'b1);
      send(0, 8'h7F, 14'h1FFF, 1'b1, 21'd1040257, 1'b0);
      send(0, 8'h80, 14'h1FFF, 1'b1, 21'h100080, 1'b0);
      send(0, 8'h7F, 14'h2000, 1'b1, 21'h102000, 1'b0);
      send(0, 8'h81, 14'h3FFF, 1'b1, 21'd127, 1'b0);
      drain();
      check("ovf_count_3", 32'(cnt[0]), 32'd3);

      // Truncation, rounding and plain shift configurations.
      send(1, 8'd255, 14'd16383, 1'b0, 21'd2080513, 1'b1);
      send(1, 8'h80, 14'h2000, 1'b1, 21'd1048576, 1'b1);
      send(1, 8'd200, 14'd1000, 1'b0, 21'd200000, 1'b0);
      send(2, 8'd3, 14'd3, 1'b0, 21'd1, 1'b0);
      send(2, 8'd7, 14'd1, 1'b0, 21'd0, 1'b0);
      send(2, 8'd8, 14'd1, 1'b0, 21'd1, 1'b0);
      send(2, 8'hFF, 14'd9, 1'b1, 21'h1FFFFF, 1'b0);
      send(2, 8'hFF, 14'd8, 1'b1, 21'd0, 1'b0);
      send(3, 8'd8, 14'd1, 1'b0, 21'd0, 1'b0);
      send(3, 8'd16, 14'd1, 1'b0, 21'd1, 1'b0);
      send(3, 8'hFF, 14'd9, 1'b1, 21'h1FFFFF, 1'b0);
      send(3, 8'd255, 14'd16383, 1'b0, 21'd261104, 1'b0);
      drain();

      // Backpressure: random out_ready with a forced six-cycle stall window.
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               send(0, bp_a[i], bp_b[i], bp_s[i], bp_d[i], bp_o[i]);
            end
         end
         begin
            for (int j = 0; j < 40; j++) begin
               rdy0 = (j >= 6 && j < 12) ? 1'b0 : 1'($urandom_range(0, 1));
               @(posedge ap_clk);
               #1;
            end
            rdy0 = 1'b1;
         end
      join
      drain();
      check("ovf_count_4", 32'(cnt[0]), 32'd4);

      // Clear coinciding with an overflowing consume must leave the count at zero.
      send(0, 8'd255, 14'd16383, 1'b0, 21'd2097151, 1'b1);
      @(posedge ap_clk); #1;
      @(posedge ap_clk); #1;
      check("clr_setup_valid", 32'(ov[0]), 32'd1);
      clr = 1'b1;
      @(posedge ap_clk); #1;
      clr = 1'b0;
      check("clr_priority", 32'(cnt[0]), 32'd0);
      send(0, 8'd255, 14'd16383, 1'b0, 21'd2097151, 1'b1);
      drain();
      check("ovf_count_after_clr", 32'(cnt[0]), 32'd1);

      // Reset with three beats in flight: nothing of them may emerge afterwards.
      send(0, 8'd1, 14'd1, 1'b0, 21'd1, 1'b0);
      send(0, 8'd2, 14'd2, 1'b0, 21'd4, 1'b0);
      send(0, 8'd3, 14'd3, 1'b0, 21'd9, 1'b0);
      ap_rst_n = 1'b0;
      q0.delete();
      #1;
      check("inflight_rst_valid", 32'(ov[0]), 32'd0);
      check("inflight_rst_dout", 32'(dq[0]), 32'd0);
      check("inflight_rst_count", 32'(cnt[0]), 32'd0);
      @(posedge ap_clk); #1;
      ap_rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", 32'(irdy[0]), 32'd1);
      repeat (8) @(posedge ap_clk);
      #1;
      check("post_rst_no_stale", 32'(ov[0]), 32'd0);
      send(0, 8'd12, 14'd12, 1'b0, 21'd144, 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded 500000 time units, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
